// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single shared memory port.
// Each requester gets a one-deep pending register; a small FSM issues one
// access at a time as a single-cycle strobe and waits for the memory to go idle.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned WORD_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [WORD_WIDTH-1:0] p0_din,
    output logic [WORD_WIDTH-1:0] p0_dout,
    input  logic                  p0_re,
    input  logic                  p0_we,
    output logic                  p0_ready,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [WORD_WIDTH-1:0] p1_din,
    output logic [WORD_WIDTH-1:0] p1_dout,
    input  logic                  p1_re,
    input  logic                  p1_we,
    output logic                  p1_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_din,
    input  logic [WORD_WIDTH-1:0] mem_dout,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e                state_q;
    logic [1:0]            pend_q;
    logic [1:0]            req_we_q;
    logic [ADDR_WIDTH-1:0] req_addr_q [2];
    logic [WORD_WIDTH-1:0] req_din_q  [2];
    logic [WORD_WIDTH-1:0] dout_q     [2];
    logic                  grant_q;
    logic                  last_grant_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WORD_WIDTH-1:0] mem_din_q;
    logic                  mem_re_q;
    logic                  mem_we_q;

    logic [1:0]            port_re;
    logic [1:0]            port_we;
    logic [ADDR_WIDTH-1:0] port_addr [2];
    logic [WORD_WIDTH-1:0] port_din  [2];
    logic                  grant_sel;

    assign port_re      = {p1_re, p0_re};
    assign port_we      = {p1_we, p0_we};
    assign port_addr[0] = p0_addr;
    assign port_addr[1] = p1_addr;
    assign port_din[0]  = p0_din;
    assign port_din[1]  = p1_din;

    // Round-robin pick: a lone pending port wins, a tie goes to the port not granted last.
    always_comb begin
        grant_sel = pend_q[1];
        if (pend_q == 2'b11) begin
            grant_sel = ~last_grant_q;
        end
    end

    // Request capture plus the IDLE/ISSUE/WAIT access sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pend_q       <= '0;
            req_we_q     <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                req_addr_q[n] <= '0;
                req_din_q[n]  <= '0;
                dout_q[n]     <= '0;
            end
        end else begin
            // A port only accepts while idle; a combined re+we is a write.
            for (int n = 0; n < 2; n++) begin
                if (!pend_q[n] && (port_re[n] || port_we[n])) begin
                    pend_q[n]     <= 1'b1;
                    req_addr_q[n] <= port_addr[n];
                    req_din_q[n]  <= port_din[n];
                    req_we_q[n]   <= port_we[n];
                end
            end

            case (state_q)
                StIdle: begin
                    if ((|pend_q) && mem_ready) begin
                        grant_q      <= grant_sel;
                        last_grant_q <= grant_sel;
                        mem_addr_q   <= req_addr_q[grant_sel];
                        mem_din_q    <= req_din_q[grant_sel];
                        mem_we_q     <= req_we_q[grant_sel];
                        mem_re_q     <= ~req_we_q[grant_sel];
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    // Strobe lasts exactly one cycle; address/data stay put.
                    mem_re_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= StWait;
                end
                StWait: begin
                    if (mem_ready) begin
                        pend_q[grant_q] <= 1'b0;
                        if (!req_we_q[grant_q]) begin
                            dout_q[grant_q] <= mem_dout;
                        end
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign p0_ready = ~pend_q[0];
    assign p1_ready = ~pend_q[1];
    assign p0_dout  = dout_q[0];
    assign p1_dout  = dout_q[1];
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_re   = mem_re_q;
    assign mem_we   = mem_we_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, address width of every port.
REQ-002 SHALL have parameter WORD_WIDTH, default 64, data width of every port.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 pN_addr  input  ADDR_WIDTH  requester N address, where N = 0 or 1 here and in REQ-007 to REQ-011.
REQ-007 pN_din  input  WORD_WIDTH  requester N write data.
REQ-008 pN_dout  output  WORD_WIDTH  requester N read data.
REQ-009 pN_re  input  1  requester N read strobe.
REQ-010 pN_we  input  1  requester N write strobe.
REQ-011 pN_ready  output  1  requester N idle; a strobe is accepted only while this is high.
REQ-012 mem_addr  output  ADDR_WIDTH  shared memory address.
REQ-013 mem_din  output  WORD_WIDTH  shared memory write data.
REQ-014 mem_dout  input  WORD_WIDTH  shared memory read data.
REQ-015 mem_re  output  1  shared memory read strobe.
REQ-016 mem_we  output  1  shared memory write strobe.
REQ-017 mem_ready  input  1  shared memory idle; it falls at the edge that samples a strobe and rises when the access is done.

Function
REQ-018 Acceptance: at an edge with pN_ready=1 and (pN_re|pN_we)=1, SHALL latch addr, din and op into a per-port pending register and drive pN_ready=0 from that edge.
REQ-019 Op selection: if pN_re and pN_we are both 1, SHALL treat the request as a write and ignore the read.
REQ-020 Strobes sampled while pN_ready=0 SHALL be ignored, and no pN_* input changes a pending request.
REQ-021 State machine: SHALL have states IDLE, ISSUE and WAIT, entering IDLE after reset.
REQ-022 IDLE to ISSUE: when at least one port is pending and mem_ready=1, SHALL grant one port and register mem_addr/mem_din/mem_re/mem_we from that port's pending request.
REQ-023 ISSUE: mem_re or mem_we SHALL be high for exactly this one cycle; the next edge SHALL move to WAIT and clear mem_re/mem_we.
REQ-024 WAIT to IDLE: at the first edge with mem_ready=1, SHALL clear the granted port's pending flag, set its pN_ready=1 and, for a read, load pN_dout<=mem_dout.
REQ-025 The state machine SHALL spend at least one cycle in IDLE between grants.
REQ-026 Arbitration: SHALL keep a last_grant register; if one port is pending it wins, and if both are pending the port != last_grant wins; last_grant SHALL update on each grant.
REQ-027 pN_dout SHALL hold its value until the next completed read for that port; a write SHALL not change pN_dout.
REQ-028 mem_addr/mem_din SHALL hold their last issued values outside ISSUE.
REQ-029 Latency: an accepted request on an idle arbiter with an idle memory SHALL drive its mem strobe 1 cycle after acceptance.
REQ-030 Completion: the port SHALL see pN_ready=1 one edge after the memory raises mem_ready.
REQ-031 Simultaneous acceptance: when both ports are accepted at the same edge, both SHALL pend and both SHALL be served back-to-back by round-robin.
REQ-032 Starvation bound: while a port is pending, SHALL grant the other port at most once before granting it.

Reset
REQ-033 While rst=1, SHALL set state=IDLE, clear both pending flags, set last_grant=1 (port 0 wins the first tie), mem_re=mem_we=0, mem_addr=mem_din=0, p0_dout=p1_dout=0 and p0_ready=p1_ready=1.
REQ-034 Reset during ISSUE or WAIT SHALL abandon the in-flight access with no completion reported and no pN_dout update.

Verification
REQ-035 Reset, then p0 writes addr 1 with data 0x0123456789abcdef -> mem_we high for exactly 1 cycle with mem_addr=1; p0_ready stays low until the edge after mem_ready returns.
REQ-036 p0 reads addr 1 -> p0_dout=0x0123456789abcdef when p0_ready returns to 1; p1_dout stays 0.
REQ-037 p0 writes (257, 123) and p1 writes (256, 321) at the same edge -> p0 is granted first, then p1; a subsequent read of 257 returns 123 and a read of 256 returns 321.
REQ-038 p0 and p1 each issue 4 back-to-back reads with both always pending -> grants strictly alternate 0,1,0,1,... with no port granted twice in a row.
REQ-039 p1 asserts re and we together at addr 5 with din 7 -> a write occurs (mem_we=1, mem_re=0) and a read of 5 then returns 7.
REQ-040 rst asserted during WAIT of a p0 read -> both ports ready, mem strobes low and p0_dout=0; the next request proceeds normally.
